// File: rtl/matrix_product_checker.sv
// Sequential 3x3 signed matrix multiplier (C = A*B) built around one MAC.
// It also reports whether C equals scale times the identity matrix, which
// confirms a matrix/adjugate pair coming from the inversion stage.
module matrix_product_checker #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*DATA_W-1:0]  a_flat,
  input  logic [9*DATA_W-1:0]  b_flat,
  input  logic [ACC_W-1:0]     scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*ACC_W-1:0]   c_flat,
  output logic                 is_scaled_identity,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MAC  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] a_r [0:8];
  logic signed [DATA_W-1:0] b_r [0:8];
  logic signed [ACC_W-1:0]  scale_r;
  logic signed [ACC_W-1:0]  c_r [0:8];
  logic signed [ACC_W-1:0]  acc;
  logic [1:0]               i, j, k;
  logic                     match;
  logic                     out_valid_r;

  logic [3:0]                 a_idx, b_idx, c_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_base, sum, target;
  logic                       last_term;
  logic                       accept;

  // Sign-extend a full-precision product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // Accumulate modulo 2^ACC_W; overflow wraps silently.
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] x,
                                                       input logic signed [ACC_W-1:0] y);
    return x + y;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state == MAC) || (state == DONE);
  assign out_valid = out_valid_r;
  assign is_scaled_identity = match;
  assign last_term = (i == 2'd2) && (j == 2'd2) && (k == 2'd2);

  // Operand addressing and the single multiply-accumulate term for (i,j,k).
  always_comb begin
    a_idx    = {1'b0, i, 1'b0} + {2'b00, i} + {2'b00, k};
    b_idx    = {1'b0, k, 1'b0} + {2'b00, k} + {2'b00, j};
    c_idx    = {1'b0, i, 1'b0} + {2'b00, i} + {2'b00, j};
    prod     = a_r[a_idx] * b_r[b_idx];
    acc_base = (k == 2'd0) ? '0 : acc;
    sum      = wrap_add(acc_base, sext_prod(prod));
    target   = (i == j) ? scale_r : '0;
  end

  // Present the result matrix row-major, c11 in the low bits.
  always_comb begin
    c_flat = '0;
    for (int n = 0; n < 9; n++) c_flat[n*ACC_W +: ACC_W] = c_r[n];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = accept ? MAC : IDLE;
      MAC:     state_nxt = last_term ? DONE : MAC;
      DONE:    state_nxt = (out_valid_r && out_ready) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept; operands are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < 9; n++) begin
        a_r[n] <= a_flat[n*DATA_W +: DATA_W];
        b_r[n] <= b_flat[n*DATA_W +: DATA_W];
      end
      scale_r <= scale;
    end
  end

  // Counters, accumulator, result matrix, match bit and output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      match       <= 1'b0;
      out_valid_r <= 1'b0;
      for (int n = 0; n < 9; n++) c_r[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            match <= 1'b1;
          end
        end
        MAC: begin
          acc <= sum;
          if (k == 2'd2) begin
            c_r[c_idx] <= sum;
            match      <= match && (sum == target);
            k          <= '0;
            if (j == 2'd2) begin
              j <= '0;
              i <= (i == 2'd2) ? 2'd0 : i + 2'd1;
            end else begin
              j <= j + 2'd1;
            end
          end else begin
            k <= k + 2'd1;
          end
        end
        DONE: begin
          if (!out_valid_r)   out_valid_r <= 1'b1;
          else if (out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
